jam_cost_arbiter: RTL
=====================

# jam_cost_arbiter

Round-robin arbiter that shares the single combinational cost-ROM port (W/J in, Cost out) between several job-assignment search engines. Each engine can search a different partition of the permutation space in parallel. The arbiter grants one requester at a time for bursts of up to MAX_BURST lookups and muxes that requester's worker/job address onto W/J. It registers the returned Cost, and the matching response is pulsed back to the owner one cycle later.

## Interface
- N_REQ, 4: number of requesters (2..8).
- MAX_BURST, 8: maximum lookups per grant (1..8).

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester lookup request; held high while lookups remain.
- req_w  in  3*N_REQ  worker index; requester i uses bits [3i+2:3i].
- req_j  in  3*N_REQ  job index; same packing as req_w.
- gnt  out  N_REQ  registered one-hot grant; all zero when idle.
- rsp_valid  out  N_REQ  registered one-cycle pulse to the requester whose lookup produced rsp_cost.
- rsp_cost  out  7  registered Cost of the last lookup.
- W  out  3  ROM worker address; combinational mux of the owner's req_w, 0 when idle.
- J  out  3  ROM job address; combinational mux of the owner's req_j, 0 when idle.
- Cost  in  7  ROM data; valid in the same cycle as W/J.
- busy  out  1  equals |gnt.

## Operation
- States: IDLE (gnt=0) and SERVE (exactly one gnt bit set; its index is "owner").
- Lookup: any SERVE cycle with req[owner]=1.
  - At the closing edge: rsp_cost <= Cost, rsp_valid[owner] <= 1, burst_cnt++.
  - rsp_valid returns to 0 on every cycle without a lookup.
- A SERVE cycle with req[owner]=0 performs no lookup and is a release cycle.
- Rearbitration at the closing edge of a SERVE cycle happens when req[owner]=0, or when this cycle's lookup brings burst_cnt to MAX_BURST.
- Rearbitration also happens on every IDLE edge.
- Priority: (ptr+1), (ptr+2), …, ptr, mod N_REQ.
  - ptr is the last owner; it is 0 after reset.
  - Immediately after reset the order is therefore 1, 2, …, 0. Requester 0 wins first only when it is the sole requester.
- Winner found: gnt <= onehot(winner), ptr <= winner, burst_cnt <= 0, state SERVE.
- No request pending: gnt <= 0, state IDLE.
- An owner whose burst is exhausted and which still requests is the lowest-priority candidate. If it is alone, it is re-granted with no gap cycle.
- Otherwise, SERVE stays with the same owner.
- Requester contract:
  - Present the address while req is high.
  - Advance to the next address after each cycle in which gnt[i] & req[i].
  - Drop req only after the final lookup cycle.
- burst_cnt is 3 bits plus a saturation compare; no wrap reaches the datapath.
- Reset values: gnt=0, rsp_valid=0, rsp_cost=0, busy=0, W=0, J=0, ptr=0, burst_cnt=0, state IDLE.

## Timing
- Request latency:
  - req rises in cycle t, arbiter IDLE.
  - gnt is visible in t+1, which is also the first lookup cycle.
  - rsp_valid and rsp_cost are visible in t+2.
- Lookup response latency is one cycle. Throughput is one lookup per cycle while grants are back-to-back.
- Burst handoff is a full burst: no dead cycle. The last lookup of owner A is in cycle k, the first lookup of B in k+1.
- Voluntary release costs one dead cycle: the cycle in which req[owner]=0 while granted.
- Simultaneous events:
  - A new request arriving during another's burst waits for the burst end.
  - Requests arriving in the same cycle are ordered by the rotating priority.
- RST mid-burst:
  - At the next edge all outputs take their reset values.
  - An in-flight rsp_valid is discarded.
  - After reset, arbitration restarts from ptr=0.
- MAX_BURST=1: the grant rotates every cycle among the active requesters.

## Test plan
- Reset check: RST held for 2 cycles with req=4'b1111 → during RST and the cycle after release, gnt=0, rsp_valid=0, W=J=0, busy=0.
- Single requester: the bench ROM model is Cost = 8·W + J.
  - Stimulus: req[0] for 3 lookups with (W,J) = (0,5), (1,5), (2,5).
  - Response: gnt=4'b0001 at t+1; rsp_valid[0] pulses t+2..t+4 with rsp_cost = 5, 13, 21.
  - gnt returns to 0 one cycle after req drops.
- Full contention: req=4'b1111 held, MAX_BURST=8.
  - Grant order: 1, 2, 3, 0, 1, each for 8 consecutive lookups.
  - 32 rsp_valid pulses arrive in 32 consecutive cycles with no gap.
- Sole continuous requester: req[2] only, 20 lookups.
  - gnt stays 4'b0100 across the burst boundaries at lookups 8 and 16.
  - 20 consecutive rsp_valid[2] pulses.
- Voluntary release: req[1] owner drops req after 3 lookups while req[3] is high.
  - One dead cycle with no rsp_valid.
  - gnt=4'b1000 at the following edge.
- Reset mid-burst: RST asserted during the 4th lookup of requester 2.
  - Next cycle: gnt=0 and rsp_valid=0.
  - After release with req=4'b0101: requester 2 is granted first, because the priority order after reset is 1, 2, 3, 0.

Source files
------------

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: round-robin burst arbiter sharing one combinational cost-ROM port between search engines
module jam_cost_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_REQ-1:0]   req,
   input  logic [3*N_REQ-1:0] req_w,
   input  logic [3*N_REQ-1:0] req_j,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [6:0]         rsp_cost,
   output logic [2:0]         W,
   output logic [2:0]         J,
   input  logic [6:0]         Cost,
   output logic               busy
);
   localparam int PW = $clog2(N_REQ);
   typedef enum logic {IDLE, SERVE} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] ptr, ptr_nxt, win;
   logic [2:0] burst_cnt, cnt_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic lookup, last, found, rearb;
   assign busy = |gnt;
   assign lookup = state == SERVE && |(req & gnt);
   assign last = lookup && burst_cnt == 3'(MAX_BURST - 1);
   assign rearb = !lookup || last;
   // rotating-priority winner search and next-state selection; the current owner ranks last
   always_comb begin
      int rank, best;
      rank = 0;
      best = N_REQ + 1;
      win = ptr;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         rank = (i + N_REQ - int'(ptr)) % N_REQ;
         rank = rank == 0 ? N_REQ : rank;
         if (req[i] && rank < best) begin
            best = rank;
            win = PW'(i);
            found = 1'b1;
         end
      end
      state_nxt = state;
      gnt_nxt = gnt;
      ptr_nxt = ptr;
      cnt_nxt = lookup ? burst_cnt + 3'd1 : burst_cnt;
      if (rearb) begin
         state_nxt = found ? SERVE : IDLE;
         gnt_nxt = found ? (N_REQ'(1)) << win : '0;
         ptr_nxt = found ? win : ptr;
         cnt_nxt = '0;
      end
   end
   // ROM address mux: the granted requester's worker/job index, zero when nobody owns the port
   always_comb begin
      W = '0;
      J = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            W = req_w[3*i +: 3];
            J = req_j[3*i +: 3];
         end
      end
   end
   // state, grant and response registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         gnt <= '0;
         ptr <= '0;
         burst_cnt <= '0;
         rsp_valid <= '0;
         rsp_cost <= '0;
      end else begin
         state <= state_nxt;
         gnt <= gnt_nxt;
         ptr <= ptr_nxt;
         burst_cnt <= cnt_nxt;
         rsp_valid <= lookup ? gnt : '0;
         if (lookup) rsp_cost <= Cost;
      end
   end
endmodule
